// File: rtl/pcm_ddram_writer.sv
// pcm_ddram_writer
//   Captures the PCM ROM bytes from the hps_io download stream and packs them
//   into 64-bit DDRAM words. Each byte lands in the lane that the ch1 reader
//   extracts with data[(addr[2:0]*8)+:8]. A word is written when its last lane
//   arrives, when the stream moves to a different word, or when the download
//   window closes with a partial word still buffered.
//
//   Optional feature: define PCM_LOADER_CHECKSUM_EN to accumulate a 16-bit
//   running sum of the captured bytes. Without it, checksum is tied to zero.
//
// Ports
//   clk_sys, reset_n          : clock, asynchronous active-low reset
//   ioctl_download/wr/addr/
//   dout/index                : hps_io download stream (input)
//   ioctl_wait                : backpressure towards hps_io
//   DDRAM_BUSY                : DDRAM not accepting the current request
//   DDRAM_ADDR/DIN/BE/WE/
//   BURSTCNT                  : single-beat DDRAM write request
//   done                      : region fully written since the last download start
//   overrun                   : sticky, a byte was dropped
//   checksum                  : running byte sum (zero when the feature is off)
module pcm_ddram_writer #(
  parameter logic [24:0] PCM_BASE      = 25'hE8000,
  parameter int          PCM_SIZE_LOG2 = 18,
  parameter logic [28:0] DDR_BASE      = 29'h0600_0000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [7:0]  ioctl_index,
  output logic        ioctl_wait,
  input  logic        DDRAM_BUSY,
  output logic [28:0] DDRAM_ADDR,
  output logic [63:0] DDRAM_DIN,
  output logic [7:0]  DDRAM_BE,
  output logic        DDRAM_WE,
  output logic [7:0]  DDRAM_BURSTCNT,
  output logic        done,
  output logic        overrun,
  output logic [15:0] checksum
);

  localparam int WW = PCM_SIZE_LOG2 - 3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  // Place a byte in its lane of an otherwise zero word.
  function automatic logic [63:0] lane_data(input logic [2:0] lane, input logic [7:0] b);
    lane_data = {56'd0, b} << {lane, 3'b000};
  endfunction

  // One-hot byte enable for a lane.
  function automatic logic [7:0] lane_be(input logic [2:0] lane);
    lane_be = 8'd1 << lane;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [63:0]   buf_data_q, buf_data_d;
  logic [7:0]    buf_be_q, buf_be_d;
  logic [WW-1:0] buf_word_q, buf_word_d;
  logic          skid_v_q, skid_v_d;
  logic [WW-1:0] skid_word_q, skid_word_d;
  logic [2:0]    skid_lane_q, skid_lane_d;
  logic [7:0]    skid_data_q, skid_data_d;
  logic          flush_pend_q, flush_pend_d;
  logic          done_q, done_d;
  logic          overrun_q, overrun_d;
  logic          we_q, we_d;
  logic [28:0]   addr_q, addr_d;
  logic [63:0]   din_q, din_d;
  logic [7:0]    be_q, be_d;
  logic          wait_q, wait_d;
  logic          dl_prev_q;

  logic [24:0]   off_full_s;
  logic          in_range_s;
  logic          cap_s;
  logic [WW-1:0] cap_word_s;
  logic [2:0]    cap_lane_s;
  logic          rise_s;
  logic          fall_s;
  logic [1:0]    st_s;
  logic          skid_busy_s;
  logic          take_s;
  logic          drop_s;
  logic          acc_s;
  logic [63:0]   merged_data_s;
  logic [7:0]    merged_be_s;

  // Subtraction cannot wrap once ioctl_addr >= PCM_BASE, so the upper bits
  // of the offset tell whether the byte lies inside the region.
  assign off_full_s = ioctl_addr - PCM_BASE;
  assign in_range_s = (ioctl_addr >= PCM_BASE) && ((off_full_s >> PCM_SIZE_LOG2) == 25'd0);
  assign cap_s      = ioctl_wr && ioctl_download && (ioctl_index == 8'd0) && in_range_s;
  assign cap_word_s = off_full_s[PCM_SIZE_LOG2-1:3];
  assign cap_lane_s = off_full_s[2:0];

  assign rise_s = ioctl_download && !dl_prev_q;
  assign fall_s = !ioctl_download && dl_prev_q;

  // A download restart acts as a synchronous clear: the FSM below works on
  // the already-cleared view so a byte in the restart cycle is not lost.
  assign st_s        = rise_s ? S_IDLE : state_q;
  assign skid_busy_s = skid_v_q && !rise_s;
  assign take_s      = cap_s && !skid_busy_s;
  assign drop_s      = cap_s && skid_busy_s;
  assign acc_s       = we_q && !DDRAM_BUSY && !rise_s;

  assign merged_data_s = buf_data_q | lane_data(cap_lane_s, ioctl_dout);
  assign merged_be_s   = buf_be_q | lane_be(cap_lane_s);

  // Next-state logic for the packer, skid register and DDRAM request.
  always_comb begin
    state_d      = st_s;
    buf_data_d   = rise_s ? 64'd0 : buf_data_q;
    buf_be_d     = rise_s ? 8'd0 : buf_be_q;
    buf_word_d   = buf_word_q;
    skid_v_d     = skid_busy_s;
    skid_word_d  = skid_word_q;
    skid_lane_d  = skid_lane_q;
    skid_data_d  = skid_data_q;
    flush_pend_d = rise_s ? 1'b0 : flush_pend_q;
    done_d       = rise_s ? 1'b0 : done_q;
    overrun_d    = rise_s ? 1'b0 : overrun_q;
    we_d         = rise_s ? 1'b0 : we_q;
    addr_d       = addr_q;
    din_d        = rise_s ? 64'd0 : din_q;
    be_d         = rise_s ? 8'd0 : be_q;

    if (drop_s) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_d;
    end

    case (st_s)
      S_IDLE: begin
        if (take_s) begin
          buf_data_d = lane_data(cap_lane_s, ioctl_dout);
          buf_be_d   = lane_be(cap_lane_s);
          buf_word_d = cap_word_s;
          state_d    = S_FILL;
        end else if (fall_s) begin
          done_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_FILL: begin
        if (fall_s) begin
          we_d    = 1'b1;
          addr_d  = DDR_BASE + {{(29-WW){1'b0}}, buf_word_q};
          din_d   = buf_data_q;
          be_d    = buf_be_q;
          state_d = S_FLUSH;
        end else if (take_s) begin
          if (cap_word_s != buf_word_q) begin
            // Stream moved on: ship the buffer and park the new byte.
            skid_v_d    = 1'b1;
            skid_word_d = cap_word_s;
            skid_lane_d = cap_lane_s;
            skid_data_d = ioctl_dout;
            we_d        = 1'b1;
            addr_d      = DDR_BASE + {{(29-WW){1'b0}}, buf_word_q};
            din_d       = buf_data_q;
            be_d        = buf_be_q;
            state_d     = S_WRITE;
          end else begin
            buf_data_d = merged_data_s;
            buf_be_d   = merged_be_s;
            if (cap_lane_s == 3'd7) begin
              we_d    = 1'b1;
              addr_d  = DDR_BASE + {{(29-WW){1'b0}}, buf_word_q};
              din_d   = merged_data_s;
              be_d    = merged_be_s;
              state_d = S_WRITE;
            end else begin
              state_d = S_FILL;
            end
          end
        end else begin
          state_d = S_FILL;
        end
      end

      S_WRITE: begin
        if (fall_s) begin
          flush_pend_d = 1'b1;
        end else begin
          flush_pend_d = flush_pend_d;
        end
        if (take_s) begin
          skid_v_d    = 1'b1;
          skid_word_d = cap_word_s;
          skid_lane_d = cap_lane_s;
          skid_data_d = ioctl_dout;
        end else begin
          skid_v_d = skid_v_d;
        end
        if (acc_s) begin
          we_d       = 1'b0;
          buf_data_d = 64'd0;
          buf_be_d   = 8'd0;
          if (skid_v_d) begin
            // The parked byte opens the next word.
            buf_data_d = lane_data(skid_lane_d, skid_data_d);
            buf_be_d   = lane_be(skid_lane_d);
            buf_word_d = skid_word_d;
            skid_v_d   = 1'b0;
            if (flush_pend_d) begin
              flush_pend_d = 1'b0;
              we_d         = 1'b1;
              addr_d       = DDR_BASE + {{(29-WW){1'b0}}, skid_word_d};
              din_d        = lane_data(skid_lane_d, skid_data_d);
              be_d         = lane_be(skid_lane_d);
              state_d      = S_FLUSH;
            end else begin
              state_d = S_FILL;
            end
          end else if (flush_pend_d) begin
            flush_pend_d = 1'b0;
            done_d       = 1'b1;
            state_d      = S_IDLE;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_WRITE;
        end
      end

      S_FLUSH: begin
        if (acc_s) begin
          we_d       = 1'b0;
          buf_data_d = 64'd0;
          buf_be_d   = 8'd0;
          done_d     = 1'b1;
          state_d    = S_IDLE;
        end else begin
          state_d = S_FLUSH;
        end
      end

      default: begin
        state_d = S_IDLE;
        we_d    = 1'b0;
      end
    endcase

    wait_d = (state_d == S_WRITE) || (state_d == S_FLUSH) || skid_v_d;
  end

  // State and output registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      buf_data_q   <= 64'd0;
      buf_be_q     <= 8'd0;
      buf_word_q   <= '0;
      skid_v_q     <= 1'b0;
      skid_word_q  <= '0;
      skid_lane_q  <= 3'd0;
      skid_data_q  <= 8'd0;
      flush_pend_q <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= DDR_BASE;
      din_q        <= 64'd0;
      be_q         <= 8'd0;
      wait_q       <= 1'b0;
      dl_prev_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_data_q   <= buf_data_d;
      buf_be_q     <= buf_be_d;
      buf_word_q   <= buf_word_d;
      skid_v_q     <= skid_v_d;
      skid_word_q  <= skid_word_d;
      skid_lane_q  <= skid_lane_d;
      skid_data_q  <= skid_data_d;
      flush_pend_q <= flush_pend_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      be_q         <= be_d;
      wait_q       <= wait_d;
      dl_prev_q    <= ioctl_download;
    end
  end

`ifdef PCM_LOADER_CHECKSUM_EN
  logic [15:0] cs_q, cs_d;

  // Running sum of every byte that was actually kept.
  always_comb begin
    cs_d = rise_s ? 16'd0 : cs_q;
    if (take_s) begin
      cs_d = cs_d + {8'd0, ioctl_dout};
    end else begin
      cs_d = cs_d;
    end
  end

  // Checksum register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cs_q <= 16'd0;
    end else begin
      cs_q <= cs_d;
    end
  end

  assign checksum = cs_q;
`else
  assign checksum = 16'd0;
`endif

  assign ioctl_wait     = wait_q;
  assign DDRAM_WE       = we_q;
  assign DDRAM_ADDR     = addr_q;
  assign DDRAM_DIN      = din_q;
  assign DDRAM_BE       = be_q;
  assign DDRAM_BURSTCNT = 8'd1;
  assign done           = done_q;
  assign overrun        = overrun_q;

endmodule
